// File: rtl/prbs_gen_chk_if.sv
// rtl/prbs_gen_chk_if.sv - generator and checker signal bundle for prbs_gen_chk
interface prbs_gen_chk_if #(
    parameter int DW    = 1,
    parameter int ERR_W = 16
);
    logic             i_enable;
    logic             i_valid;
    logic [1:0]       i_mode;
    logic [DW-1:0]    o_data;
    logic             o_valid;
    logic [DW-1:0]    i_rx_data;
    logic             i_rx_valid;
    logic             i_clr_err;
    logic             o_lock;
    logic [ERR_W-1:0] o_err_cnt;

    modport master (
        output i_enable, i_valid, i_mode, i_rx_data, i_rx_valid, i_clr_err,
        input  o_data, o_valid, o_lock, o_err_cnt
    );

    modport slave (
        input  i_enable, i_valid, i_mode, i_rx_data, i_rx_valid, i_clr_err,
        output o_data, o_valid, o_lock, o_err_cnt
    );
endinterface

// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - PRBS7/9/15/31 generator with self-synchronising checker
module prbs_gen_chk #(
    parameter int          DW       = 1,
    parameter logic [30:0] SEED     = 31'h1AA,
    parameter int          LOCK_CNT = 16,
    parameter int          LOSS_CNT = 4,
    parameter int          ERR_W    = 16
) (
    input logic           clk,
    input logic           reset,
    prbs_gen_chk_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [ERR_W+6:0] ERR_MAX = {7'd0, {ERR_W{1'b1}}};

    typedef enum logic {SEARCH, LOCKED} chk_state_t;

    function automatic logic [30:0] seed_of(input logic [1:0] m);
        logic [30:0] mask;
        case (m)
            2'd0:    mask = 31'h0000_007F;
            2'd1:    mask = 31'h0000_01FF;
            2'd2:    mask = 31'h0000_7FFF;
            default: mask = 31'h7FFF_FFFF;
        endcase
        return ((SEED & mask) == 31'd0) ? mask : (SEED & mask);
    endfunction

    logic [1:0]       mode_q;
    logic [30:0]      gen_s;
    logic [30:0]      gen_next;
    logic [DW-1:0]    gen_word;
    logic [DW-1:0]    data_q;
    logic             valid_q;
    logic [30:0]      chk_r;
    logic [30:0]      chk_next;
    logic [DW-1:0]    bit_err;
    logic [5:0]       err_pop;
    logic [ERR_W+6:0] err_sum;
    logic [ERR_W-1:0] err_sat;
    logic [ERR_W-1:0] err_q;
    logic             lock_q;
    logic [MW-1:0]    match_cnt;
    logic [LW-1:0]    loss_cnt;
    chk_state_t       state;
    logic [4:0]       hi_idx;
    logic [4:0]       tap_idx;
    logic             mode_chg;

    assign mode_chg = (bus.i_mode != mode_q);

    always_comb begin
        case (mode_q)
            2'd0:    begin hi_idx = 5'd6;  tap_idx = 5'd5;  end
            2'd1:    begin hi_idx = 5'd8;  tap_idx = 5'd4;  end
            2'd2:    begin hi_idx = 5'd14; tap_idx = 5'd13; end
            default: begin hi_idx = 5'd30; tap_idx = 5'd27; end
        endcase
    end

    // DW serial steps unrolled; step k lands in o_data[DW-1-k] (oldest bit at the MSB)
    always_comb begin : gen_comb
        logic fb;
        gen_next = gen_s;
        gen_word = '0;
        for (int k = 0; k < DW; k++) begin
            fb = gen_next[hi_idx] ^ gen_next[tap_idx];
            gen_next = {gen_next[29:0], fb};
            gen_word[DW-1-k] = fb;
        end
    end

    // Checker predicts each bit from previously received bits, so it needs no seed
    always_comb begin : chk_comb
        logic b;
        chk_next = chk_r;
        bit_err  = '0;
        err_pop  = '0;
        for (int k = 0; k < DW; k++) begin
            b = bus.i_rx_data[DW-1-k];
            bit_err[DW-1-k] = b ^ chk_next[hi_idx] ^ chk_next[tap_idx];
            chk_next = {chk_next[29:0], b};
        end
        for (int k = 0; k < DW; k++) begin
            err_pop = err_pop + 6'(bit_err[k]);
        end
        err_sum = {7'd0, err_q} + {{(ERR_W+1){1'b0}}, err_pop};
        err_sat = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= 2'd0;
            gen_s   <= seed_of(2'd0);
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (mode_chg) begin
            mode_q  <= bus.i_mode;
            gen_s   <= seed_of(bus.i_mode);
            valid_q <= 1'b0;
        end else if (bus.i_enable && bus.i_valid) begin
            gen_s   <= gen_next;
            data_q  <= gen_word;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            match_cnt <= '0;
            loss_cnt  <= '0;
            lock_q    <= 1'b0;
            err_q     <= '0;
            chk_r     <= '0;
        end else begin
            if (bus.i_clr_err) begin
                err_q <= '0;
            end
            if (mode_chg) begin
                state     <= SEARCH;
                match_cnt <= '0;
                loss_cnt  <= '0;
                lock_q    <= 1'b0;
            end else if (bus.i_rx_valid) begin
                chk_r <= chk_next;
                // The word that completes the lock was checked in SEARCH and is not counted
                if (state == LOCKED && !bus.i_clr_err) begin
                    err_q <= err_sat;
                end
                case (state)
                    SEARCH: begin
                        if (bit_err != '0) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state     <= LOCKED;
                            lock_q    <= 1'b1;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + MW'(1);
                        end
                    end
                    default: begin
                        if (bit_err == '0) begin
                            loss_cnt <= '0;
                        end else if (loss_cnt == LW'(LOSS_CNT - 1)) begin
                            state     <= SEARCH;
                            lock_q    <= 1'b0;
                            loss_cnt  <= '0;
                            match_cnt <= '0;
                        end else begin
                            loss_cnt <= loss_cnt + LW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_lock    = lock_q;
    assign bus.o_err_cnt = err_q;
endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - directed/randomised bench for prbs_gen_chk against a bit-history model
module tb_prbs_gen_chk;
    localparam int DW      = 8;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = 15;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    prbs_gen_chk_if #(.DW(DW), .ERR_W(ERR_W)) bus ();
    prbs_gen_chk #(.DW(DW), .ERR_W(ERR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Model: sequences are kept as bit histories, newest at the back
    bit          gq[$];
    bit          hist[$];
    int          m_mode;
    logic [7:0]  m_data;
    bit          m_valid;
    bit          m_locked;
    int          m_match, m_loss, m_err;

    function automatic int ord(input int m);
        return (m == 0) ? 7 : (m == 1) ? 9 : (m == 2) ? 15 : 31;
    endfunction

    function automatic int tap(input int m);
        return (m == 0) ? 6 : (m == 1) ? 5 : (m == 2) ? 14 : 28;
    endfunction

    task automatic load_seed(input int m);
        longint mask, s;
        mask = (64'd1 << ord(m)) - 1;
        s = 64'h1AA & mask;
        if (s == 0) s = mask;
        gq.delete();
        for (int j = ord(m) - 1; j >= 0; j--) gq.push_back(s[j]);
    endtask

    task automatic model_reset();
        load_seed(0);
        m_mode = 0; m_data = 0; m_valid = 0;
        hist.delete();
        for (int j = 0; j < 31; j++) hist.push_back(1'b0);
        m_locked = 0; m_match = 0; m_loss = 0; m_err = 0;
    endtask

    task automatic model_step(input bit en, input bit vld, input int mode,
                              input logic [7:0] rx, input bit rxv, input bit clr);
        int n, t, errs;
        bit b, e;
        if (mode != m_mode) begin
            load_seed(mode);
            m_mode = mode; m_valid = 0;
            m_locked = 0; m_match = 0; m_loss = 0;
        end else begin
            n = ord(m_mode); t = tap(m_mode);
            if (en && vld) begin
                for (int k = 0; k < DW; k++) begin
                    b = gq[gq.size() - n] ^ gq[gq.size() - t];
                    gq.push_back(b);
                    if (gq.size() > 64) void'(gq.pop_front());
                    m_data[DW-1-k] = b;
                end
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
            if (rxv) begin
                errs = 0;
                for (int k = 0; k < DW; k++) begin
                    b = rx[DW-1-k];
                    e = b ^ hist[hist.size() - n] ^ hist[hist.size() - t];
                    errs += int'(e);
                    hist.push_back(b);
                    if (hist.size() > 64) void'(hist.pop_front());
                end
                if (m_locked) begin
                    m_err = (m_err + errs > ERR_MAX) ? ERR_MAX : m_err + errs;
                    if (errs == 0) m_loss = 0;
                    else begin
                        m_loss++;
                        if (m_loss == 4) begin m_locked = 0; m_loss = 0; m_match = 0; end
                    end
                end else begin
                    if (errs != 0) m_match = 0;
                    else begin
                        m_match++;
                        if (m_match == 16) begin m_locked = 1; m_match = 0; end
                    end
                end
            end
        end
        if (clr) m_err = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_step(bus.i_enable, bus.i_valid, int'(bus.i_mode), bus.i_rx_data,
                        bus.i_rx_valid, bus.i_clr_err);
        #1;
        chk("o_data", 32'(bus.o_data), 32'(m_data));
        chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
        chk("o_lock", 32'(bus.o_lock), 32'(m_locked));
        chk("o_err_cnt", 32'(bus.o_err_cnt), 32'(m_err));
    endtask

    // Loopback of the previously generated word, optionally corrupted by flip
    task automatic drive(input bit en, input bit vld, input logic [7:0] flip, input bit clr);
        bus.i_enable   = en;
        bus.i_valid    = vld;
        bus.i_rx_data  = m_data ^ flip;
        bus.i_rx_valid = m_valid;
        bus.i_clr_err  = clr;
        step();
    endtask

    initial begin
        int saved;
        reset = 1'b1;
        bus.i_enable = 0; bus.i_valid = 0; bus.i_mode = 2'd1;
        bus.i_rx_data = '0; bus.i_rx_valid = 0; bus.i_clr_err = 0;
        model_reset();
        #3;
        chk("reset_data", 32'(bus.o_data), 32'd0);
        chk("reset_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_lock", 32'(bus.o_lock), 32'd0);
        chk("reset_err", 32'(bus.o_err_cnt), 32'd0);
        step();
        reset = 1'b0;

        drive(0, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0);
        drive(1, 1, 8'h00, 0);
        chk("first_bits", 32'(bus.o_data[7:6]), 32'h2);

        for (int i = 0; i < 300; i++) drive(1, ($urandom % 4) != 0, 8'h00, 0);
        chk("lock_mode1", 32'(bus.o_lock), 32'd1);
        for (int i = 0; i < 2000; i++) drive(1, 1, 8'h00, 0);
        chk("clean_err_zero", 32'(bus.o_err_cnt), 32'd0);

        drive(1, 1, 8'h00, 1);
        drive(1, 1, 8'h01 << $urandom_range(0, 7), 0);
        for (int i = 0; i < 6; i++) drive(1, 1, 8'h00, 0);
        chk("single_flip_err", 32'(bus.o_err_cnt), 32'd3);
        chk("single_flip_lock", 32'(bus.o_lock), 32'd1);

        for (int i = 0; i < 4; i++) drive(1, 1, 8'hFF, 0);
        chk("loss_lock", 32'(bus.o_lock), 32'd0);
        for (int i = 0; i < 30; i++) drive(1, 1, 8'h00, 0);
        chk("relock", 32'(bus.o_lock), 32'd1);

        drive(1, 1, 8'h00, 1);
        for (int r = 0; r < 3; r++) begin
            drive(1, 1, 8'hFF, 0);
            for (int i = 0; i < 4; i++) drive(1, 1, 8'h00, 0);
        end
        chk("saturate_err", 32'(bus.o_err_cnt), 32'(ERR_MAX));
        chk("saturate_lock", 32'(bus.o_lock), 32'd1);

        drive(1, 1, 8'hFF, 1);
        chk("clr_wins", 32'(bus.o_err_cnt), 32'd0);
        for (int i = 0; i < 5; i++) drive(1, 1, 8'h00, 0);

        saved = m_err;
        bus.i_mode = 2'd3;
        drive(1, 1, 8'h00, 0);
        chk("mode_chg_valid", 32'(bus.o_valid), 32'd0);
        chk("mode_chg_lock", 32'(bus.o_lock), 32'd0);
        chk("mode_chg_err", 32'(bus.o_err_cnt), 32'(saved));
        for (int i = 0; i < 100; i++) drive(1, ($urandom % 5) != 0, 8'h00, 0);
        chk("lock_mode3", 32'(bus.o_lock), 32'd1);

        bus.i_mode = 2'd0;
        for (int i = 0; i < 100; i++) drive(1, ($urandom % 5) != 0, 8'h00, 0);
        chk("lock_mode0", 32'(bus.o_lock), 32'd1);
        bus.i_mode = 2'd2;
        for (int i = 0; i < 100; i++) drive(1, ($urandom % 5) != 0, 8'h00, 0);
        chk("lock_mode2", 32'(bus.o_lock), 32'd1);

        drive(1, 1, 8'h00, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_data", 32'(bus.o_data), 32'd0);
        chk("async_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("async_rst_lock", 32'(bus.o_lock), 32'd0);
        chk("async_rst_err", 32'(bus.o_err_cnt), 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) drive(1, 1, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
